// File: rtl/down_counter_pkg.sv
// Shared types and constants for the 32-bit down counter/timer.
//   dc_state_t : controller state (IDLE, RUN, PAUSE, EXPIRED), 2-bit encoded
//   DC_WIDTH   : default counter / load-value width
package down_counter_pkg;

    localparam int unsigned DC_WIDTH = 32;

    typedef enum logic [1:0] {
        DC_IDLE    = 2'd0,
        DC_RUN     = 2'd1,
        DC_PAUSE   = 2'd2,
        DC_EXPIRED = 2'd3
    } dc_state_t;

endpackage

// File: rtl/down_counter32.sv
// Loadable down counter/timer with one-shot and periodic (auto-reload) modes.
// Emits a registered one-cycle done pulse when the count reaches zero.
//
// Ports:
//   clk        in  : single clock, rising edge
//   reset      in  : synchronous, active-high reset
//   load       in  : capture load_value into count and reload registers
//   load_value in  : value captured on load            [WIDTH]
//   start      in  : begin or resume countdown
//   stop       in  : pause countdown
//   periodic   in  : mode, sampled on an accepted start (1 = auto-reload)
//   tick       in  : decrement enable while running
//   count      out : current count, registered          [WIDTH]
//   busy       out : high in RUN
//   paused     out : high in PAUSE
//   done       out : one-cycle pulse as count reaches 0
//   expired    out : sticky one-shot completion flag (EXPIRED state)
module down_counter32
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             expired
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    dc_state_t        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= DC_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    // Priority: load > stop > start > decrement. A stop in any state
    // blocks a simultaneous start.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = DC_IDLE;
        end else begin
            unique case (state_q)
                DC_IDLE: begin
                    if (!stop && start && (count_q != '0)) begin
                        mode_d  = periodic;
                        state_d = DC_RUN;
                    end
                end
                DC_RUN: begin
                    if (stop) begin
                        state_d = DC_PAUSE;
                    end else if (tick) begin
                        if (count_q == '0) begin
                            // Reached only after a terminal count in periodic
                            // mode, or a restart with reload == 0.
                            if (mode_q) begin
                                count_d = reload_q;
                            end else begin
                                state_d = DC_EXPIRED;
                            end
                        end else if (count_q == ONE) begin
                            count_d = '0;
                            done_d  = 1'b1;
                            if (!mode_q) begin
                                state_d = DC_EXPIRED;
                            end
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                DC_PAUSE: begin
                    if (!stop && start) begin
                        state_d = DC_RUN;
                    end
                end
                DC_EXPIRED: begin
                    if (!stop && start) begin
                        count_d = reload_q;
                        mode_d  = periodic;
                        state_d = DC_RUN;
                    end
                end
                default: begin
                    state_d = DC_IDLE;
                end
            endcase
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign busy    = (state_q == DC_RUN);
    assign paused  = (state_q == DC_PAUSE);
    assign expired = (state_q == DC_EXPIRED);

endmodule

// File: tb/tb_down_counter32.sv
module tb_down_counter32;

    logic        clk = 1'b0;
    logic        reset, load, start, stop, periodic, tick;
    logic [31:0] load_value;
    logic [31:0] count;
    logic        busy, paused, done, expired;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    down_counter32 #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .periodic   (periodic),
        .tick       (tick),
        .count      (count),
        .busy       (busy),
        .paused     (paused),
        .done       (done),
        .expired    (expired)
    );

    // Inputs change on the falling edge; outputs are sampled on the falling
    // edge after the rising edge that consumed them.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] c, input logic b,
                           input logic p, input logic d, input logic e);
        chk({tag, ".count"},   count,   c);
        chk({tag, ".busy"},    busy,    b);
        chk({tag, ".paused"},  paused,  p);
        chk({tag, ".done"},    done,    d);
        chk({tag, ".expired"}, expired, e);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
        periodic = 1'b0; tick = 1'b0; load_value = '0;
        @(negedge clk);

        // Reset two cycles, then idle
        cyc(); cyc();
        reset = 1'b0;
        chk_all("reset", 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_all("idle", 0, 0, 0, 0, 0);
        end
        start = 1'b1; cyc(); start = 1'b0;
        chk_all("start_zero_ignored", 0, 0, 0, 0, 0);

        // One-shot countdown from 5
        load = 1'b1; load_value = 32'd5; cyc(); load = 1'b0;
        chk_all("os_load", 5, 0, 0, 0, 0);
        periodic = 1'b0; tick = 1'b1; start = 1'b1; cyc(); start = 1'b0;
        chk_all("os_start", 5, 1, 0, 0, 0);
        for (int i = 4; i >= 0; i--) begin
            cyc();
            chk_all("os_run", i, (i != 0), 0, (i == 0), (i == 0));
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_all("os_hold", 0, 0, 0, 0, 1);
        end

        // Periodic from 3: period of 4 ticks
        load = 1'b1; load_value = 32'd3; cyc(); load = 1'b0;
        chk_all("per_load", 3, 0, 0, 0, 0);
        periodic = 1'b1; start = 1'b1; cyc(); start = 1'b0; periodic = 1'b0;
        chk_all("per_start", 3, 1, 0, 0, 0);
        for (int j = 0; j < 12; j++) begin
            int unsigned e;
            e = 3 - ((j + 1) % 4);
            cyc();
            chk_all("per_run", e, 1, 0, (e == 0), 0);
        end

        // Pause and resume
        load = 1'b1; load_value = 32'd10; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        chk_all("pr_start", 10, 1, 0, 0, 0);
        cyc(); cyc(); cyc(); cyc();
        chk_all("pr_4dec", 6, 1, 0, 0, 0);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk_all("pr_stop", 6, 0, 1, 0, 0);
        cyc(); cyc();
        chk_all("pr_hold", 6, 0, 1, 0, 0);
        start = 1'b1; cyc(); start = 1'b0;
        chk_all("pr_resume", 6, 1, 0, 0, 0);
        cyc();
        chk_all("pr_at5", 5, 1, 0, 0, 0);
        for (int i = 4; i >= 0; i--) begin
            cyc();
            chk_all("pr_run", i, (i != 0), 0, (i == 0), (i == 0));
        end

        // Load wins over the terminal decrement
        load = 1'b1; load_value = 32'd8; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        chk_all("ld_at1", 1, 1, 0, 0, 0);
        load = 1'b1; load_value = 32'd20; cyc(); load = 1'b0;
        chk_all("ld_term", 20, 0, 0, 0, 0);

        // Stop wins over the terminal decrement
        load = 1'b1; load_value = 32'd2; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        chk_all("st_at1", 1, 1, 0, 0, 0);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk_all("st_term", 1, 0, 1, 0, 0);

        // Stop and start together while running -> PAUSE
        tick = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        chk_all("ss_run", 1, 1, 0, 0, 0);
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk_all("ss_pause", 1, 0, 1, 0, 0);
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; cyc();
        chk_all("ss_finish", 0, 0, 0, 1, 1);

        // Tick every other cycle: 6 decrements over 12 cycles
        load = 1'b1; load_value = 32'd6; cyc(); load = 1'b0;
        tick = 1'b0; start = 1'b1; cyc(); start = 1'b0;
        chk_all("tg_start", 6, 1, 0, 0, 0);
        for (int c = 1; c <= 12; c++) begin
            tick = (c % 2 == 0);
            cyc();
            chk_all("tg_run", 6 - c / 2, (c != 12), 0, (c == 12), (c == 12));
        end

        // Reset mid-run overrides everything
        tick = 1'b1;
        load = 1'b1; load_value = 32'd6; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        chk_all("rs_at3", 3, 1, 0, 0, 0);
        reset = 1'b1; start = 1'b1; load_value = 32'd9; cyc();
        reset = 1'b0; start = 1'b0;
        chk_all("rs_mid", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/down_counter32.md
# down_counter32

Loadable 32-bit down counter/timer with one-shot and periodic modes, the decrementing counterpart to the team's 32-bit up counter. Software or a controller loads a start value, starts the countdown, and receives a one-cycle `done` pulse when the count reaches zero. In periodic mode the block reloads automatically, so it serves as the lab timer/tick generator feeding downstream sequencing logic.

## Interface
- `WIDTH`, default 32: counter and load-value width.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  capture `load_value` into count and reload registers.
- `load_value`  in  WIDTH  value captured on `load`.
- `start`  in  1  begin or resume countdown.
- `stop`  in  1  pause countdown.
- `periodic`  in  1  mode, sampled only on an accepted `start` (1 = auto-reload).
- `tick`  in  1  decrement enable while running; tie high for per-cycle counting.
- `count`  out  WIDTH  current count, registered.
- `busy`  out  1  high in RUN.
- `paused`  out  1  high in PAUSE.
- `done`  out  1  registered one-cycle pulse when count reaches 0.
- `expired`  out  1  sticky one-shot completion flag.

## Operation
- Registers: `count`, `reload`, `mode`, state, `done`, `expired`. All are 0 or IDLE on reset. All outputs read 0 in the first cycle after reset.
- States: IDLE, RUN, PAUSE, EXPIRED. `busy`/`paused`/`expired` decode directly from the state register.
- Priority each cycle: `load` > `stop` > `start` > decrement.
- `load` (any state): count <= reload <= `load_value`; state <= IDLE; `done` not asserted; an active run is aborted.
- IDLE + `start`: if count != 0: mode <= `periodic`, state <= RUN. If count == 0: ignored, stay IDLE.
- RUN + `stop`: state <= PAUSE, count holds. PAUSE + `start`: state <= RUN, mode unchanged.
- RUN, `tick`=1, count > 1: count <= count-1.
- RUN, `tick`=1, count == 1: count <= 0, `done` <= 1.
  - One-shot: state <= EXPIRED.
  - Periodic: stay RUN.
- RUN, `tick`=1, count == 0 (periodic only): count <= reload.
  - Period is reload+1 ticks.
- `tick`=0 in RUN: count holds and no pulse.
- EXPIRED: count holds 0. `start` -> count <= reload, mode <= `periodic`, state <= RUN. `expired` drops on that edge.
- Unsigned arithmetic; count never wraps below 0. WIDTH-bit compare against 1 and 0 only.

## Timing
- Latency: `start` sampled at edge k, so `busy` is high after edge k. The first decrement happens at edge k+1 if `tick` is high.
- Load N, start, `tick` tied high (one-shot): `done` is high exactly one cycle, the same cycle `count` first reads 0. That cycle is N cycles after `busy` rises. `expired` rises with `done` and stays high.
- `done` never exceeds one cycle, except periodic with reload == 1, where it recurs every 2 ticks.
- `stop` on the edge where count would go 1->0: stop wins, count stays 1, no `done`.
- `load` on the terminal edge: load wins, no `done`.
- `reset` mid-run: next cycle everything is 0/IDLE regardless of other inputs.

## Structure
- Package `down_counter_pkg`:
  - `dc_state_t` enum (IDLE, RUN, PAUSE, EXPIRED), 2-bit encoding.
  - `DC_WIDTH` = 32 constant.
- Single module, no sub-module: one FSM plus one datapath register. Separating them adds ports without benefit.

## Test plan
- Reset 2 cycles, then idle 5 cycles -> count=0, busy=0, done=0, expired=0. `start` with count 0 is ignored.
- Load 5, start, one-shot, tick=1 -> count 5,4,3,2,1,0. done high only in the cycle count=0. expired=1 and stays high. count holds 0 for 10 more cycles.
- Load 3, start periodic, run 12 cycles -> count 3,2,1,0,3,2,1,0,... with done pulses spaced 4 cycles apart.
- Load 10, start, stop after 4 decrements -> count holds 6 with paused=1. start -> resumes at 5 with no extra done.
- Load 8, start, load 20 at count=1 -> no done, count=20, state IDLE. Separately, stop and start together in RUN -> PAUSE.
- Load 6, tick toggling every other cycle -> done after 12 cycles. Assert reset at count=3 -> next cycle all outputs 0.
